// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding,
// width bounds and a behavioural reference used by benches.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // Returns {ovf, bout, diff[31:0]} for an w-bit a - b - bin.
    function automatic logic [33:0] ref_sub(input logic [31:0] a, input logic [31:0] b,
                                            input logic bin, input int unsigned w);
        logic [31:0] mask;
        logic [32:0] full;
        logic [31:0] d;
        logic        bo;
        logic        ov;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        full = {1'b0, a & mask} - {1'b0, b & mask} - {32'd0, bin};
        d    = full[31:0] & mask;
        bo   = full[32];
        ov   = (a[w-1] ^ b[w-1]) & (d[w-1] ^ a[w-1]);
        return {ov, bo, d};
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
interface serial_subtractor_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (output start, a, b, bin,
                    input  ready, busy, done, diff, bout, ovf);
    modport slave  (input  start, a, b, bin,
                    output ready, busy, done, diff, bout, ovf);
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: the bit slice of the serial datapath.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b - bin), LSB first, one bit per clock,
// with a start/ready/busy/done handshake.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_nx;
    logic             accept;
    logic             last;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic             brw;
    logic             a_msb;
    logic             b_msb;
    logic             bit_d;
    logic             bit_bo;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ovf_q;

    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (brw),
        .d    (bit_d),
        .bout (bit_bo)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            S_IDLE: if (bus.start) begin
                accept   = 1'b1;
                state_nx = S_RUN;
            end
            S_RUN:  if (last) state_nx = S_DONE;
            // Back-to-back: a start in DONE skips the idle cycle.
            S_DONE: if (bus.start) begin
                accept   = 1'b1;
                state_nx = S_RUN;
            end else begin
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            brw     <= 1'b0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            brw   <= bus.bin;
            cnt   <= '0;
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
        end else if (state == S_RUN) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            diff_sr <= {bit_d, diff_sr[WIDTH-1:1]};
            brw     <= bit_bo;
            cnt     <= last ? cnt : cnt + CW'(1);
            // Publish on the final shift so results are valid in DONE.
            if (last) begin
                diff_q <= {bit_d, diff_sr[WIDTH-1:1]};
                bout_q <= bit_bo;
                ovf_q  <= (a_msb ^ b_msb) & (bit_d ^ a_msb);
            end
        end
    end

    assign bus.ready = (state == S_IDLE) || (state == S_DONE);
    assign bus.busy  = (state == S_RUN);
    assign bus.done  = (state == S_DONE);
    assign bus.diff  = diff_q;
    assign bus.bout  = bout_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed + exhaustive checks of serial_subtractor with a result scoreboard.
module tb_serial_subtractor;
    import serial_arith_pkg::*;

    typedef struct {
        logic [31:0] diff;
        logic        bout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(4)) bus4 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    int   errors = 0;
    int   checks = 0;
    int   dones8 = 0;
    int   dones4 = 0;
    exp_t q8[$];
    exp_t q4[$];
    exp_t e8;
    exp_t e4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (bus8.done === 1'b1) begin
            dones8++;
            checks++;
            assert (q8.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_done8 observed=%0h expected=%0h", bus8.diff, 0);
            end
            if (q8.size() != 0) begin
                e8 = q8.pop_front();
                chk("diff8", {24'd0, bus8.diff}, e8.diff);
                chk("bout8", {31'd0, bus8.bout}, {31'd0, e8.bout});
                chk("ovf8",  {31'd0, bus8.ovf},  {31'd0, e8.ovf});
            end
        end
        if (bus4.done === 1'b1) begin
            dones4++;
            checks++;
            assert (q4.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_done4 observed=%0h expected=%0h", bus4.diff, 0);
            end
            if (q4.size() != 0) begin
                e4 = q4.pop_front();
                chk("diff4", {28'd0, bus4.diff}, e4.diff);
                chk("bout4", {31'd0, bus4.bout}, {31'd0, e4.bout});
                chk("ovf4",  {31'd0, bus4.ovf},  {31'd0, e4.ovf});
            end
        end
    end

    task automatic push8(input logic [7:0] d, input logic bo, input logic ov);
        exp_t e;
        e.diff = {24'd0, d};
        e.bout = bo;
        e.ovf  = ov;
        q8.push_back(e);
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        bus8.bin   = bin;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
    endtask

    task automatic wait_done8(input string tag);
        int prev;
        prev = dones8;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (dones8 != prev) break;
        end
        chk(tag, dones8 - prev, 1);
    endtask

    task automatic measure_latency(input string tag);
        int n;
        n = 1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus8.done === 1'b1) break;
        end
        chk(tag, n, 9);
        #1;
    endtask

    initial begin
        exp_t        e;
        logic [33:0] r;
        int          prev;

        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        chk("rst_ready", {31'd0, bus8.ready}, 1);
        chk("rst_busy",  {31'd0, bus8.busy},  0);
        chk("rst_done",  {31'd0, bus8.done},  0);
        chk("rst_diff",  {24'd0, bus8.diff},  0);
        chk("rst_bout",  {31'd0, bus8.bout},  0);
        chk("rst_ovf",   {31'd0, bus8.ovf},   0);
        rst_n = 1'b1;
        @(negedge clk);

        push8(8'h37, 1'b0, 1'b0);
        issue8(8'h5A, 8'h23, 1'b0);
        chk("accept_busy",  {31'd0, bus8.busy},  1);
        chk("accept_ready", {31'd0, bus8.ready}, 0);
        measure_latency("latency_first");
        @(negedge clk);

        push8(8'hF0, 1'b1, 1'b0);
        issue8(8'h10, 8'h20, 1'b0);
        wait_done8("done_10_20");
        push8(8'hFF, 1'b1, 1'b0);
        issue8(8'h00, 8'h00, 1'b1);
        wait_done8("done_00_00_b1");
        push8(8'h7F, 1'b0, 1'b1);
        issue8(8'h80, 8'h01, 1'b0);
        wait_done8("done_80_01");
        push8(8'h80, 1'b1, 1'b1);
        issue8(8'h7F, 8'hFF, 1'b0);
        wait_done8("done_7f_ff");
        @(negedge clk);

        // Start mid-RUN is ignored; start held in DONE chains the next op.
        push8(8'h87, 1'b0, 1'b0);
        issue8(8'hC3, 8'h3C, 1'b0);
        chk("hold_diff_run", {24'd0, bus8.diff}, 32'h80);
        @(negedge clk);
        issue8(8'hFF, 8'h01, 1'b1);
        chk("ignored_busy", {31'd0, bus8.busy}, 1);
        for (int i = 0; i < 20; i++) begin
            if (bus8.done === 1'b1) break;
            @(negedge clk);
        end
        chk("done_before_b2b", {31'd0, bus8.done}, 1);
        push8(8'hFE, 1'b1, 1'b0);
        issue8(8'h01, 8'h02, 1'b1);
        chk("b2b_busy", {31'd0, bus8.busy}, 1);
        measure_latency("latency_b2b");
        @(negedge clk);

        // Reset mid-RUN: aborts with no done pulse.
        prev = dones8;
        issue8(8'hA5, 8'h5A, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mid_rst_ready", {31'd0, bus8.ready}, 1);
        chk("mid_rst_busy",  {31'd0, bus8.busy},  0);
        chk("mid_rst_done",  {31'd0, bus8.done},  0);
        chk("mid_rst_diff",  {24'd0, bus8.diff},  0);
        chk("mid_rst_bout",  {31'd0, bus8.bout},  0);
        chk("mid_rst_ovf",   {31'd0, bus8.ovf},   0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("no_done_after_rst", dones8 - prev, 0);

        // WIDTH=4 exhaustive against the reference function.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    r = ref_sub(32'(a), 32'(b), c[0], 4);
                    e.diff = r[31:0];
                    e.bout = r[32];
                    e.ovf  = r[33];
                    q4.push_back(e);
                    prev = dones4;
                    bus4.start = 1'b1;
                    bus4.a     = 4'(a);
                    bus4.b     = 4'(b);
                    bus4.bin   = c[0];
                    @(posedge clk);
                    @(negedge clk);
                    bus4.start = 1'b0;
                    for (int i = 0; i < 20; i++) begin
                        @(negedge clk);
                        #1;
                        if (dones4 != prev) break;
                    end
                end
            end
        end
        chk("done_count4", dones4, 512);
        chk("q8_empty", q8.size(), 0);
        chk("q4_empty", q4.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
